// File: rtl/tt_program_loader_if.sv
// Pin-side, core-side and memory-side signals of the program loader.
// The slave modport is the loader's view; the master modport is the wrapper's view.
interface tt_program_loader_if;
  logic        load_mode;
  logic [7:0]  in_byte;
  logic        in_strobe;
  logic [31:0] core_address;
  logic [31:0] core_write_data;
  logic [3:0]  core_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_enable;
  logic        core_reset;
  logic        busy;
  logic        err;
  logic [15:0] word_count;

  modport master (
    output load_mode, in_byte, in_strobe,
    output core_address, core_write_data, core_write_enable,
    input  mem_address, mem_write_data, mem_write_enable,
    input  core_reset, busy, err, word_count
  );

  modport slave (
    input  load_mode, in_byte, in_strobe,
    input  core_address, core_write_data, core_write_enable,
    output mem_address, mem_write_data, mem_write_enable,
    output core_reset, busy, err, word_count
  );
endinterface

// File: rtl/tt_program_loader.sv
// Byte-serial program loader: assembles little-endian pin bytes into 32-bit
// memory writes while holding the core in reset, then hands the bus back.
module tt_program_loader #(
  parameter int SIZE = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  tt_program_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WRITE} state_t;

  localparam logic [32:0] SIZE_W = 33'(SIZE);

  state_t      state_q, state_d;
  logic        load_meta_q, load_s_q, load_prev_q;
  logic        strobe_meta_q, strobe_s_q, strobe_prev_q;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [15:0] word_count_q, word_count_d;
  logic        err_q, err_d;
  logic        hold_q, hold_d;

  logic byte_ev;
  logic load_rise;
  logic in_range;

  assign byte_ev   = strobe_s_q & ~strobe_prev_q;
  assign load_rise = load_s_q & ~load_prev_q;
  assign in_range  = ({1'b0, addr_q} < SIZE_W);

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    addr_d       = addr_q;
    word_d       = word_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    hold_d       = load_s_q | (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (load_rise) begin
          state_d      = ADDR;
          byte_idx_d   = 2'd0;
          word_count_d = 16'd0;
          err_d        = 1'b0;
        end
      end
      ADDR: begin
        // An exit from ADDR never produced a usable word, so it is always an error.
        if (!load_s_q) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          byte_idx_d = 2'd0;
        end else if (byte_ev) begin
          addr_d[{byte_idx_q, 3'b000} +: 8] = bus.in_byte;
          if (byte_idx_q == 2'd3) begin
            addr_d[1:0] = 2'b00;
            state_d     = DATA;
            byte_idx_d  = 2'd0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      DATA: begin
        if (!load_s_q) begin
          state_d    = IDLE;
          byte_idx_d = 2'd0;
          if (byte_idx_q != 2'd0) err_d = 1'b1;
        end else if (byte_ev) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = bus.in_byte;
          if (byte_idx_q == 2'd3) begin
            state_d    = WRITE;
            byte_idx_d = 2'd0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      WRITE: begin
        if (in_range) begin
          if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
        end else begin
          err_d = 1'b1;
        end
        addr_d     = addr_q + 32'd4;
        byte_idx_d = 2'd0;
        state_d    = load_s_q ? DATA : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      load_meta_q   <= 1'b0;
      load_s_q      <= 1'b0;
      load_prev_q   <= 1'b0;
      strobe_meta_q <= 1'b0;
      strobe_s_q    <= 1'b0;
      strobe_prev_q <= 1'b0;
      byte_idx_q    <= 2'd0;
      addr_q        <= 32'd0;
      word_q        <= 32'd0;
      word_count_q  <= 16'd0;
      err_q         <= 1'b0;
      hold_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      load_meta_q   <= bus.load_mode;
      load_s_q      <= load_meta_q;
      load_prev_q   <= load_s_q;
      strobe_meta_q <= bus.in_strobe;
      strobe_s_q    <= strobe_meta_q;
      strobe_prev_q <= strobe_s_q;
      byte_idx_q    <= byte_idx_d;
      addr_q        <= addr_d;
      word_q        <= word_d;
      word_count_q  <= word_count_d;
      err_q         <= err_d;
      hold_q        <= hold_d;
    end
  end

  assign bus.core_reset = ~rst_n | hold_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err        = err_q;
  assign bus.word_count = word_count_q;

  // While held, the loader owns the memory port; the enable only fires for an in-range WRITE.
  always_comb begin
    if (hold_q) begin
      bus.mem_address      = addr_q;
      bus.mem_write_data   = word_q;
      bus.mem_write_enable = (state_q == WRITE && in_range) ? 4'hF : 4'h0;
    end else begin
      bus.mem_address      = bus.core_address;
      bus.mem_write_data   = bus.core_write_data;
      bus.mem_write_enable = bus.core_write_enable;
    end
  end

endmodule

// File: tb/tb_tt_program_loader.sv
// Directed bench for tt_program_loader: drives pin bytes and checks the
// memory writes, counters, error flag and core reset hold.
module tb_tt_program_loader;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   hold_violations;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_we[$];

  tt_program_loader_if bus_if ();

  tt_program_loader #(.SIZE(1024)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logs loader-driven memory writes; one sample per cycle.
  always @(negedge clk) begin
    if (bus_if.core_reset && bus_if.mem_write_enable != 4'h0) begin
      wr_addr.push_back(bus_if.mem_address);
      wr_data.push_back(bus_if.mem_write_data);
      wr_we.push_back(bus_if.mem_write_enable);
    end
    if (bus_if.busy && !bus_if.core_reset) hold_violations++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_we.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.in_byte   = b;
    bus_if.in_strobe = 1'b1;
    repeat (4) @(negedge clk);
    bus_if.in_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic start_load(input string tag);
    bus_if.load_mode = 1'b1;
    repeat (5) @(negedge clk);
    check({tag, "_busy_start"}, 32'(bus_if.busy), 32'd1);
    check({tag, "_err_cleared"}, 32'(bus_if.err), 32'd0);
  endtask

  // Drops load_mode, waits for IDLE, then checks the one-cycle core release.
  task automatic end_load(input string tag);
    int n;
    bus_if.load_mode = 1'b0;
    n = 0;
    while (bus_if.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_reached"}, 32'(bus_if.busy), 32'd0);
    check({tag, "_core_reset_on_idle"}, 32'(bus_if.core_reset), 32'd1);
    @(negedge clk);
    check({tag, "_core_reset_released"}, 32'(bus_if.core_reset), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    hold_violations = 0;
    rst_n = 1'b0;
    bus_if.load_mode         = 1'b0;
    bus_if.in_byte           = 8'h00;
    bus_if.in_strobe         = 1'b0;
    bus_if.core_address      = 32'h0;
    bus_if.core_write_data   = 32'h0;
    bus_if.core_write_enable = 4'h0;

    // Reset and idle
    repeat (2) @(negedge clk);
    check("rst_core_reset", 32'(bus_if.core_reset), 32'd1);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_err", 32'(bus_if.err), 32'd0);
    check("rst_word_count", 32'(bus_if.word_count), 32'd0);
    check("rst_mem_we", 32'(bus_if.mem_write_enable), 32'h0);

    rst_n = 1'b1;
    bus_if.core_address      = 32'h20;
    bus_if.core_write_data   = 32'hCAFEF00D;
    bus_if.core_write_enable = 4'h3;
    #1;
    check("idle_core_reset_before_edge", 32'(bus_if.core_reset), 32'd1);
    @(negedge clk);
    check("idle_core_reset_released", 32'(bus_if.core_reset), 32'd0);
    check("pass_mem_address", bus_if.mem_address, 32'h20);
    check("pass_mem_wdata", bus_if.mem_write_data, 32'hCAFEF00D);
    check("pass_mem_we", 32'(bus_if.mem_write_enable), 32'h3);

    // Normal load
    clear_log();
    start_load("normal");
    check("normal_held_mem_we", 32'(bus_if.mem_write_enable), 32'h0);
    send_word(32'h00000010);
    send_word(32'h44332211);
    send_word(32'h88776655);
    check("normal_word_count", 32'(bus_if.word_count), 32'd2);
    check("normal_err", 32'(bus_if.err), 32'd0);
    end_load("normal");
    check("normal_num_writes", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("normal_w0_addr", wr_addr[0], 32'h10);
      check("normal_w0_data", wr_data[0], 32'h44332211);
      check("normal_w0_we", 32'(wr_we[0]), 32'hF);
      check("normal_w1_addr", wr_addr[1], 32'h14);
      check("normal_w1_data", wr_data[1], 32'h88776655);
      check("normal_w1_we", 32'(wr_we[1]), 32'hF);
    end
    check("normal_hold_violations", 32'(hold_violations), 32'd0);
    check("normal_word_count_kept", 32'(bus_if.word_count), 32'd2);

    // Unaligned start address is forced down to a word boundary
    clear_log();
    start_load("unaligned");
    check("unaligned_word_count_cleared", 32'(bus_if.word_count), 32'd0);
    send_word(32'h00000013);
    send_word(32'hDDCCBBAA);
    end_load("unaligned");
    check("unaligned_num_writes", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("unaligned_addr", wr_addr[0], 32'h10);
      check("unaligned_data", wr_data[0], 32'hDDCCBBAA);
    end
    check("unaligned_err", 32'(bus_if.err), 32'd0);

    // Partial word at the end of the session
    clear_log();
    start_load("partial");
    send_word(32'h00000000);
    send_word(32'h04030201);
    send_byte(8'h05);
    send_byte(8'h06);
    check("partial_err_before_drop", 32'(bus_if.err), 32'd0);
    end_load("partial");
    check("partial_num_writes", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("partial_addr", wr_addr[0], 32'h0);
      check("partial_data", wr_data[0], 32'h04030201);
    end
    check("partial_word_count", 32'(bus_if.word_count), 32'd1);
    check("partial_err", 32'(bus_if.err), 32'd1);
    repeat (10) @(negedge clk);
    check("partial_err_sticky", 32'(bus_if.err), 32'd1);

    // Out of range: the word at 0x400 is suppressed
    clear_log();
    start_load("range");
    send_word(32'h000003FC);
    send_word(32'h0D0C0B0A);
    send_word(32'h1D1C1B1A);
    end_load("range");
    check("range_num_writes", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("range_addr", wr_addr[0], 32'h3FC);
      check("range_data", wr_data[0], 32'h0D0C0B0A);
    end
    check("range_word_count", 32'(bus_if.word_count), 32'd1);
    check("range_err", 32'(bus_if.err), 32'd1);

    // Reset in the middle of a data word
    clear_log();
    start_load("midrst");
    send_word(32'h00000020);
    send_byte(8'hA1);
    send_byte(8'hA2);
    rst_n = 1'b0;
    bus_if.load_mode = 1'b0;
    #1;
    check("midrst_core_reset_low_rst", 32'(bus_if.core_reset), 32'd1);
    repeat (2) @(negedge clk);
    check("midrst_busy", 32'(bus_if.busy), 32'd0);
    check("midrst_err", 32'(bus_if.err), 32'd0);
    check("midrst_word_count", 32'(bus_if.word_count), 32'd0);
    check("midrst_core_reset", 32'(bus_if.core_reset), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_core_reset_released", 32'(bus_if.core_reset), 32'd0);
    repeat (10) @(negedge clk);
    check("midrst_num_writes", 32'(wr_addr.size()), 32'd0);
    check("midrst_still_idle", 32'(bus_if.busy), 32'd0);
    check("final_hold_violations", 32'(hold_violations), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tt_program_loader.md
Name: tt_program_loader

Overview:
- Byte-serial program loader between the Tiny Tapeout pins and the core/memory pair.
- While load mode is active it holds the core in reset, owns the memory write port, and assembles little-endian bytes from the pins into 32-bit words written into memory.
- When load mode ends it returns the memory bus to the core and releases core reset.
- It sits upstream of the memory (MA) and the core, and is instantiated in the top wrapper.

Parameters:
- SIZE, 1024, memory size in bytes; a word write whose address is >= SIZE is suppressed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- load_mode  in  1  pin-level load request, asynchronous; 2-FF synchronised internally
- in_byte  in  8  pin data byte; sampled on a detected strobe edge
- in_strobe  in  1  pin byte strobe, asynchronous; 2-FF synchronised, rising edge detected
- core_address  in  32  core memory address (addr_t)
- core_write_data  in  32  core write data (data_t)
- core_write_enable  in  4  core byte write enables
- mem_address  out  32  to memory address
- mem_write_data  out  32  to memory write data
- mem_write_enable  out  4  to memory byte write enables
- core_reset  out  1  active-high reset to the core
- busy  out  1  1 while state != IDLE
- err  out  1  sticky error flag
- word_count  out  16  words written in the current load session

Behaviour:
- Synchronisation
  - load_s and strobe_s are the 2nd-stage synchronised signals.
  - byte_ev = strobe_s & ~strobe_s_d: a one-cycle pulse, 3 cycles after the pin edge.
  - in_byte is captured on byte_ev. The host holds in_byte stable from the strobe rising edge until >= 4 cycles after it.
  - Strobe minimum high and minimum low time: 3 cycles each.
- Reset (rst_n = 0 at a clock edge)
  - state = IDLE; byte_idx, addr_q, word_q and word_count = 0; err = 0.
  - Synchroniser flops clear to 0; hold_q = 1.
  - core_reset = ~rst_n | hold_q, so it is 1 while rst_n is low.
  - Reset mid-load aborts the load: no write is issued and no error is recorded.
- State machine: IDLE, ADDR, DATA, WRITE.
  - IDLE: on rising edge of load_s → ADDR; byte_idx = 0, word_count = 0, err = 0.
  - ADDR: each byte_ev shifts the byte into addr_q little-endian (byte_idx 0 → bits 7:0). On the 4th byte → DATA; addr_q[1:0] forced to 0 (alignment); byte_idx = 0.
  - DATA: each byte_ev stores the byte into word_q lane byte_idx. On the 4th byte → WRITE.
  - WRITE: lasts exactly one cycle, then → DATA.
    - If addr_q < SIZE: mem_write_enable = 4'hF, mem_write_data = word_q, mem_address = addr_q; word_count += 1 (saturates at 0xFFFF).
    - Else: enable stays 0 and err = 1.
    - In both cases addr_q += 4 (wraps mod 2^32) and byte_idx = 0.
  - load_s = 0 in ADDR or DATA → IDLE. If byte_idx != 0, or the exit is from ADDR, err = 1; partial bytes are discarded.
  - load_s = 0 in WRITE: the write completes, then → IDLE.
  - byte_ev in WRITE cannot occur, because the strobe low time is >= 3 cycles.
- Core hold
  - hold_q is registered: next = load_s | (state != IDLE).
  - core_reset falls on the first edge at which state == IDLE and load_s == 0 are both already true, i.e. one cycle after IDLE is entered.
- Bus mux (combinational)
  - hold_q = 0: mem_* = core_* passthrough.
  - hold_q = 1: mem_address = addr_q, mem_write_data = word_q, mem_write_enable = 4'hF only in the WRITE cycle, else 0.
  - Memory read data is not routed through this block.
- err and word_count hold their values after the session until the next load start or reset.
- busy = (state != IDLE).

Test Plan:
- Reset and idle:
  - rst_n = 0 for 2 cycles → core_reset = 1, busy = 0, err = 0, word_count = 0, mem_write_enable = 0.
  - Then rst_n = 1, load_mode = 0 → core_reset = 0 after 1 cycle; core_address = 0x20, core_write_enable = 4'h3 appear unchanged on mem_*.
- Normal load:
  - Stimulus: load_mode = 1; address bytes 10 00 00 00; data bytes 11 22 33 44 55 66 77 88.
  - Required: exactly two one-cycle writes, 0x44332211 at 0x10 and 0x88776655 at 0x14, each with mem_write_enable = 4'hF.
  - Required: word_count = 2, err = 0, core_reset = 1 throughout. After load_mode drops, busy = 0 and core_reset = 0 one cycle after IDLE.
- Unaligned start:
  - Stimulus: address bytes 13 00 00 00, data bytes AA BB CC DD.
  - Required: write 0xDDCCBBAA at 0x10.
- Partial word:
  - Stimulus: address 0, then 6 data bytes, then load_mode dropped.
  - Required: one write at 0x0, word_count = 1, err = 1. err stays 1 until the next load start clears it.
- Out of range (SIZE = 1024):
  - Stimulus: address FC 03 00 00, then 8 data bytes.
  - Required: write at 0x3FC occurs; write at 0x400 is suppressed (enable stays 0); word_count = 1, err = 1.
- Reset mid-load:
  - Stimulus: rst_n = 0 after 2 data bytes.
  - Required: no write, state IDLE, err = 0, word_count = 0, core_reset = 1 while rst_n is low.
